// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM/op types and RAM geometry for mem_bus_responder
package mem_bus_pkg;
    localparam int RAM_DEPTH = 512;
    localparam int RAM_ADDR_BITS = $clog2(RAM_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;
endpackage

// File: rtl/mem_bus_responder_ram.sv
// ram_512x32: single-port synchronous RAM with registered read data, array not reset
module ram_512x32
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS = RAM_ADDR_BITS
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [1<<ADDR_BITS];
    // write when enabled; read port always follows the addressed word
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: four-phase strobe responder over a 512x32 RAM (optional MEM_FAULT_EN fault checks)
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = RAM_DEPTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mem_enable512x32,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_fault
);
    localparam int ADDR_BITS = $clog2(DEPTH);
    state_t state, state_nx;
    op_t op_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, dout;
    logic [3:0] cnt;
    logic strobe, req, accept, oob_q, we;
    assign strobe = Mem_Read | Mem_Write;
    assign req = Mem_enable512x32 & (Mem_Read ^ Mem_Write);
    assign accept = (state == IDLE) && req;
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    // next state: accept, optional wait, one access, hold until strobes drop
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (cnt == 4'd0) state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            DONE:    if (!strobe) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state-decoded outputs; out-of-range writes never reach the array
    always_comb begin
        mem_busy = state != IDLE;
        we = (state == ACCESS) && (op_q == OP_WR) && !oob_q;
    end
    // request latches, wait counter, read data and ready handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            wdata_q <= '0;
            op_q <= OP_RD;
            cnt <= 4'd0;
            rdata <= '0;
            mem_ready <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= addr[ADDR_BITS-1:0];
                wdata_q <= wdata;
                op_q <= Mem_Write ? OP_WR : OP_RD;
                cnt <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == DONE && op_q == OP_RD && !oob_q) rdata <= dout;
            mem_ready <= (state == DONE) && strobe;
        end
    end
`ifdef MEM_FAULT_EN
    logic addr_oob;
    assign addr_oob = addr >= DATA_WIDTH'(DEPTH);
    // sticky fault on illegal strobe pair or out-of-range accepted address
    always_ff @(posedge clk) begin
        if (reset) begin
            oob_q <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            if (accept) oob_q <= addr_oob;
            if ((state == IDLE && Mem_enable512x32 && Mem_Read && Mem_Write) || (accept && addr_oob))
                mem_fault <= 1'b1;
        end
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[DATA_WIDTH-1:ADDR_BITS];
    assign oob_q = 1'b0;
    assign mem_fault = 1'b0;
`endif
    ram_512x32 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
        .clk(clk),
        .we(we),
        .addr(addr_q),
        .din(wdata_q),
        .dout(dout)
    );
endmodule
